sdram_arbiter: RTL and testbench

- Bus-ownership controller directly upstream of the SDRAM write stage and its sibling read and auto-refresh stages.
- Owns the refresh interval timer and grants the single SDRAM command/address bus to one stage at a time, with priority init > refresh > write > read.
- Issues the one-cycle write_en/read_en/aref_en starts and raises aref_req so an active burst yields at its next burst boundary.
- Muxes the owning stage's command and address onto the SDRAM pins.

---
 rtl/sdram_arbiter.sv | 129 ++++++++++++
 tb/tb_sdram_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// SDRAM bus-ownership arbiter: owns the refresh interval timer, grants the shared
// command/address bus to init, refresh, write or read stages, and muxes the owner onto the pins.
module sdram_arbiter #(
  parameter int unsigned AREF_PERIOD = 780,
  parameter logic [4:0]  CMD_NOP     = 5'b10111,
  parameter logic [11:0] ADDR_IDLE   = 12'h400
) (
  input  logic        S_CLK,
  input  logic        RST,
  input  logic        init_done,
  input  logic [4:0]  init_cmd,
  input  logic [11:0] init_addr,
  input  logic        aref_done,
  input  logic [4:0]  aref_cmd,
  input  logic [11:0] aref_addr,
  input  logic        wr_req,
  input  logic        wr_done,
  input  logic [4:0]  write_cmd,
  input  logic [11:0] write_addr,
  input  logic        rd_req,
  input  logic        rd_done,
  input  logic [4:0]  read_cmd,
  input  logic [11:0] read_addr,
  output logic        aref_en,
  output logic        write_en,
  output logic        read_en,
  output logic        aref_req,
  output logic        aref_miss,
  output logic [4:0]  sdram_cmd,
  output logic [11:0] sdram_addr
);

  localparam int unsigned TW = (AREF_PERIOD > 1) ? $clog2(AREF_PERIOD) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(AREF_PERIOD - 1);

  typedef enum logic [2:0] {
    INIT,
    ARBIT,
    AREF,
    WRITE,
    READ
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer;
  logic          wrap;
  logic          grant_aref, grant_write, grant_read;

  always_comb begin
    state_n = state;
    case (state)
      INIT:    if (init_done) state_n = ARBIT;
      ARBIT: begin
        if (aref_req)    state_n = AREF;
        else if (wr_req) state_n = WRITE;
        else if (rd_req) state_n = READ;
      end
      // A done pulse coincident with the start pulse belongs to a previous
      // ownership and must not release the bus.
      AREF:    if (aref_done && !aref_en) state_n = ARBIT;
      WRITE:   if (wr_done && !write_en)  state_n = ARBIT;
      READ:    if (rd_done && !read_en)   state_n = ARBIT;
      default: state_n = INIT;
    endcase
  end

  always_comb begin
    grant_aref  = (state == ARBIT) && (state_n == AREF);
    grant_write = (state == ARBIT) && (state_n == WRITE);
    grant_read  = (state == ARBIT) && (state_n == READ);
    wrap        = (state != INIT) && (timer == TIMER_LAST);
  end

  always_ff @(posedge S_CLK) begin
    if (RST) begin
      state     <= INIT;
      timer     <= '0;
      aref_en   <= 1'b0;
      write_en  <= 1'b0;
      read_en   <= 1'b0;
      aref_req  <= 1'b0;
      aref_miss <= 1'b0;
    end else begin
      state    <= state_n;
      aref_en  <= grant_aref;
      write_en <= grant_write;
      read_en  <= grant_read;

      if (state == INIT || wrap) timer <= '0;
      else                       timer <= timer + 1'b1;

      // A new interval outranks the clear from the AREF grant in the same cycle.
      if (wrap) begin
        aref_req <= 1'b1;
        if (aref_req) aref_miss <= 1'b1;
      end else if (grant_aref) begin
        aref_req <= 1'b0;
      end
    end
  end

  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_addr = ADDR_IDLE;
    case (state)
      INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      AREF: begin
        sdram_cmd  = aref_cmd;
        sdram_addr = aref_addr;
      end
      WRITE: begin
        sdram_cmd  = write_cmd;
        sdram_addr = write_addr;
      end
      READ: begin
        sdram_cmd  = read_cmd;
        sdram_addr = read_addr;
      end
      default: begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = ADDR_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomized bench for sdram_arbiter against a cycle-level ownership model.
module tb_sdram_arbiter;

  localparam int unsigned P = 16;

  logic        S_CLK = 1'b0;
  logic        RST = 1'b1;
  logic        init_done = 1'b0;
  logic [4:0]  init_cmd = '0;
  logic [11:0] init_addr = '0;
  logic        aref_done = 1'b0;
  logic [4:0]  aref_cmd = '0;
  logic [11:0] aref_addr = '0;
  logic        wr_req = 1'b0;
  logic        wr_done = 1'b0;
  logic [4:0]  write_cmd = '0;
  logic [11:0] write_addr = '0;
  logic        rd_req = 1'b0;
  logic        rd_done = 1'b0;
  logic [4:0]  read_cmd = '0;
  logic [11:0] read_addr = '0;
  logic        aref_en, write_en, read_en, aref_req, aref_miss;
  logic [4:0]  sdram_cmd;
  logic [11:0] sdram_addr;

  sdram_arbiter #(.AREF_PERIOD(P)) dut (
    .S_CLK(S_CLK), .RST(RST),
    .init_done(init_done), .init_cmd(init_cmd), .init_addr(init_addr),
    .aref_done(aref_done), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_done(wr_done), .write_cmd(write_cmd), .write_addr(write_addr),
    .rd_req(rd_req), .rd_done(rd_done), .read_cmd(read_cmd), .read_addr(read_addr),
    .aref_en(aref_en), .write_en(write_en), .read_en(read_en),
    .aref_req(aref_req), .aref_miss(aref_miss),
    .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr)
  );

  always #5 S_CLK = ~S_CLK;

  int checks = 0;
  int failures = 0;

  // Model: who owns the bus, whether this is the first owned cycle,
  // refresh pending/missed, and cycles elapsed since leaving init.
  localparam int O_INIT = 0, O_IDLE = 1, O_REF = 2, O_WR = 3, O_RD = 4;
  int m_own   = O_INIT;
  bit m_start = 1'b0;
  bit m_req   = 1'b0;
  bit m_miss  = 1'b0;
  int m_active = 0;

  // Stimulus knobs, percentages.
  bit k_rst_force = 1'b1;
  int k_rst = 0, k_init = 0, k_wr = 0, k_rd = 0, k_done = 0;

  function automatic bit rnd(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit wrap;
    bit granted_ref;
    int nxt;
    if (RST) begin
      m_own = O_INIT; m_start = 0; m_req = 0; m_miss = 0; m_active = 0;
      return;
    end
    wrap = (m_own != O_INIT) && (m_active % P == P - 1);
    nxt = m_own;
    granted_ref = 0;
    if (m_own == O_INIT && init_done) nxt = O_IDLE;
    else if (m_own == O_IDLE) begin
      if (m_req) begin nxt = O_REF; granted_ref = 1; end
      else if (wr_req) nxt = O_WR;
      else if (rd_req) nxt = O_RD;
    end else if (!m_start) begin
      if ((m_own == O_REF && aref_done) || (m_own == O_WR && wr_done) ||
          (m_own == O_RD && rd_done))
        nxt = O_IDLE;
    end
    if (wrap) begin
      if (m_req) m_miss = 1;
      m_req = 1;
    end else if (granted_ref) m_req = 0;
    if (m_own != O_INIT) m_active++;
    m_start = (m_own == O_IDLE) && (nxt != O_IDLE);
    m_own = nxt;
  endtask

  task automatic tick();
    logic [4:0]  ecmd;
    logic [11:0] eaddr;
    @(negedge S_CLK);
    RST        = k_rst_force || rnd(k_rst);
    init_done  = rnd(k_init);
    wr_req     = rnd(k_wr);
    rd_req     = rnd(k_rd);
    aref_done  = rnd(k_done);
    wr_done    = rnd(k_done);
    rd_done    = rnd(k_done);
    init_cmd   = 5'($urandom);  init_addr  = 12'($urandom);
    aref_cmd   = 5'($urandom);  aref_addr  = 12'($urandom);
    write_cmd  = 5'($urandom);  write_addr = 12'($urandom);
    read_cmd   = 5'($urandom);  read_addr  = 12'($urandom);
    #1;
    case (m_own)
      O_INIT:  begin ecmd = init_cmd;  eaddr = init_addr;  end
      O_REF:   begin ecmd = aref_cmd;  eaddr = aref_addr;  end
      O_WR:    begin ecmd = write_cmd; eaddr = write_addr; end
      O_RD:    begin ecmd = read_cmd;  eaddr = read_addr;  end
      default: begin ecmd = 5'b10111;  eaddr = 12'h400;    end
    endcase
    check_eq("sdram_cmd",  sdram_cmd,  ecmd);
    check_eq("sdram_addr", sdram_addr, eaddr);
    check_eq("aref_en",    aref_en,    m_start && m_own == O_REF);
    check_eq("write_en",   write_en,   m_start && m_own == O_WR);
    check_eq("read_en",    read_en,    m_start && m_own == O_RD);
    check_eq("aref_req",   aref_req,   m_req);
    check_eq("aref_miss",  aref_miss,  m_miss);
    model_step();
  endtask

  initial begin
    // Reset held, then init withheld, then init granted.
    repeat (3) tick();
    k_rst_force = 1'b0;
    repeat (6) tick();
    k_init = 100;
    repeat (4) tick();
    // Mixed traffic with frequent done pulses.
    k_init = 50; k_wr = 40; k_rd = 30; k_done = 15;
    repeat (800) tick();
    // Stalled owner with no done pulses: intervals elapse with refresh pending.
    k_wr = 0; k_rd = 100; k_done = 0;
    repeat (60) tick();
    k_done = 20;
    repeat (40) tick();
    // Traffic with occasional reset, including mid-burst.
    k_wr = 40; k_rd = 30; k_done = 10; k_rst = 1;
    repeat (800) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
